fetch_ctrl: RTL and testbench

Program-counter and run-control stage that sits directly upstream of the instruction ROM and decoder inside TopLevel. It sequences start/run/halt, generates the PC and resolves branches through an internal jump-target lookup table. It also keeps cycle and instruction counters for end-of-run reporting by the bench.

---
 rtl/fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// PC / run-control stage ahead of the instruction ROM: IDLE/RUN/HALTED sequencing,
// branch resolution through a jump-target LUT, saturating counters. Optional: BRANCH_STATS_EN.
module fetch_ctrl #(
   parameter  int PC_W      = 10,
   parameter  int LUT_DEPTH = 32,
   parameter  int CNT_W     = 16,
   localparam int IDX_W     = $clog2(LUT_DEPTH)
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stall,
   input  logic             halt_req,
   input  logic             branch_en,
   input  logic             branch_abs,
   input  logic [IDX_W-1:0] branch_idx,
   input  logic [7:0]       branch_off,
   input  logic             lut_we,
   input  logic [IDX_W-1:0] lut_addr,
   input  logic [PC_W-1:0]  lut_wdata,
   output logic [PC_W-1:0]  PC,
   output logic             fetch_valid,
   output logic             halt,
`ifdef BRANCH_STATS_EN
   output logic [CNT_W-1:0] taken_branch_count,
`endif
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   // state  | meaning
   // IDLE   | held by start=1; PC and counters cleared every cycle
   // RUN    | fetching; PC advances, counters count
   // HALTED | halt decoded; PC and counters frozen for readout
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              halt_q, halt_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [CNT_W-1:0]  ins_q, ins_d;
   logic [CNT_W-1:0]  tbc_q, tbc_d;
   logic [PC_W-1:0]   lut_q [LUT_DEPTH];
   logic [PC_W-1:0]   off_ext;

   assign off_ext = {{(PC_W-8){branch_off[7]}}, branch_off};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      halt_d  = halt_q;
      cyc_d   = cyc_q;
      ins_d   = ins_q;
      tbc_d   = tbc_q;
      case (state_q)
         IDLE: begin
            pc_d   = '0;
            halt_d = 1'b0;
            cyc_d  = '0;
            ins_d  = '0;
            tbc_d  = '0;
            if (!start) state_d = RUN;
         end
         RUN: begin
            if (start) begin
               state_d = IDLE;
               pc_d    = '0;
               cyc_d   = '0;
               ins_d   = '0;
               tbc_d   = '0;
            end else begin
               cyc_d = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_W'(1);
               if (!stall) begin
                  ins_d = (ins_q == CNT_MAX) ? ins_q : ins_q + CNT_W'(1);
                  if (halt_req) begin
                     state_d = HALTED;
                     halt_d  = 1'b1;
                  end else if (branch_en) begin
                     tbc_d = (tbc_q == CNT_MAX) ? tbc_q : tbc_q + CNT_W'(1);
                     pc_d  = branch_abs ? lut_q[branch_idx] : pc_q + off_ext;
                  end else begin
                     pc_d = pc_q + PC_W'(1);
                  end
               end
            end
         end
         HALTED: begin
            if (start) begin
               state_d = IDLE;
               halt_d  = 1'b0;
               pc_d    = '0;
               cyc_d   = '0;
               ins_d   = '0;
               tbc_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         halt_q  <= 1'b0;
         cyc_q   <= '0;
         ins_q   <= '0;
         tbc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         halt_q  <= halt_d;
         cyc_q   <= cyc_d;
         ins_q   <= ins_d;
         tbc_q   <= tbc_d;
      end
   end

   // Branch reads above see the pre-edge entry, so a same-edge write is read-before-write.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
      end else if (lut_we) begin
         lut_q[lut_addr] <= lut_wdata;
      end
   end

   assign PC          = pc_q;
   assign halt        = halt_q;
   assign cycle_count = cyc_q;
   assign instr_count = ins_q;
   assign fetch_valid = (state_q == RUN) && !stall;
`ifdef BRANCH_STATS_EN
   assign taken_branch_count = tbc_q;
`else
   logic unused_tbc;
   assign unused_tbc = ^tbc_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: launch, branches, stall/halt, restart, async reset, saturation.
module tb_fetch_ctrl;
   logic        CLK = 1'b0;
   logic        reset_n;
   logic        start, stall, halt_req, branch_en, branch_abs, lut_we;
   logic [4:0]  branch_idx, lut_addr;
   logic [7:0]  branch_off;
   logic [9:0]  lut_wdata;
   logic [9:0]  PC;
   logic        fetch_valid, halt;
   logic [15:0] cycle_count, instr_count;
`ifdef BRANCH_STATS_EN
   logic [15:0] taken_branch_count;
`endif
   int tests_run = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   fetch_ctrl dut (
      .CLK(CLK), .reset_n(reset_n), .start(start), .stall(stall), .halt_req(halt_req),
      .branch_en(branch_en), .branch_abs(branch_abs), .branch_idx(branch_idx),
      .branch_off(branch_off), .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
      .PC(PC), .fetch_valid(fetch_valid), .halt(halt),
`ifdef BRANCH_STATS_EN
      .taken_branch_count(taken_branch_count),
`endif
      .cycle_count(cycle_count), .instr_count(instr_count));

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_ctl();
      stall = 0; halt_req = 0; branch_en = 0; branch_abs = 0;
      branch_idx = 0; branch_off = 0; lut_we = 0; lut_addr = 0; lut_wdata = 0;
   endtask

   // Restart through IDLE, launch, and leave PC at 0 in RUN.
   task automatic relaunch();
      clear_ctl();
      start = 1; step();
      start = 0; step();
   endtask

   task automatic test_reset();
      clear_ctl();
      start = 1; reset_n = 0;
      #3;
      tests_run++;
      if (PC !== 10'd0 || halt !== 1'b0 || fetch_valid !== 1'b0 ||
          cycle_count !== 16'd0 || instr_count !== 16'd0) begin
         fails++;
         $display("FAIL reset: PC=%h halt=%b fv=%b cyc=%0d ins=%0d, required all 0",
                  PC, halt, fetch_valid, cycle_count, instr_count);
      end
      step(); reset_n = 1;
   endtask

   task automatic test_sequential();
      start = 1;
      for (int i = 0; i < 3; i++) step();
      tests_run++;
      if (PC !== 10'd0 || fetch_valid !== 1'b0) begin
         fails++; $display("FAIL idle_hold: PC=%h fv=%b, required 0 0", PC, fetch_valid);
      end
      start = 0; step();
      tests_run++;
      if (PC !== 10'd0 || fetch_valid !== 1'b1 || cycle_count !== 16'd0) begin
         fails++;
         $display("FAIL launch: PC=%h fv=%b cyc=%0d, required 0 1 0", PC, fetch_valid, cycle_count);
      end
      for (int i = 1; i <= 4; i++) begin
         step();
         tests_run++;
         if (PC !== 10'(i)) begin
            fails++; $display("FAIL seq_pc%0d: PC=%h, required %h", i, PC, 10'(i));
         end
      end
      tests_run++;
      if (cycle_count !== 16'd4 || instr_count !== 16'd4) begin
         fails++;
         $display("FAIL seq_counts: cyc=%0d ins=%0d, required 4 4", cycle_count, instr_count);
      end
   endtask

   task automatic test_abs_branch();
      clear_ctl();
      start = 1; lut_we = 1; lut_addr = 5'd5; lut_wdata = 10'h1F0; step();
      lut_we = 0; start = 0; step();
      step(); step(); step();
      tests_run++;
      if (PC !== 10'd3) begin fails++; $display("FAIL abs_pre: PC=%h, required 003", PC); end
      branch_en = 1; branch_abs = 1; branch_idx = 5'd5; step();
      tests_run++;
      if (PC !== 10'h1F0) begin fails++; $display("FAIL abs_target: PC=%h, required 1f0", PC); end
      branch_en = 0; step();
      tests_run++;
      if (PC !== 10'h1F1) begin fails++; $display("FAIL abs_next: PC=%h, required 1f1", PC); end
      branch_en = 1; lut_we = 1; lut_addr = 5'd5; lut_wdata = 10'h2AA; step();
      tests_run++;
      if (PC !== 10'h1F0) begin fails++; $display("FAIL abs_rbw_old: PC=%h, required 1f0", PC); end
      lut_we = 0; step();
      tests_run++;
      if (PC !== 10'h2AA) begin fails++; $display("FAIL abs_rbw_new: PC=%h, required 2aa", PC); end
   endtask

   task automatic test_rel_branch();
      relaunch();
      step(); step();
      branch_en = 1; branch_abs = 0; branch_off = 8'hFE; step();
      tests_run++;
      if (PC !== 10'd0) begin fails++; $display("FAIL rel_back: PC=%h, required 000", PC); end
      branch_abs = 1; branch_idx = 5'd1; lut_we = 1; lut_addr = 5'd1; lut_wdata = 10'h3FF;
      branch_en = 0; step();
      lut_we = 0; branch_en = 1; step();
      tests_run++;
      if (PC !== 10'h3FF) begin fails++; $display("FAIL rel_setup: PC=%h, required 3ff", PC); end
      branch_abs = 0; branch_off = 8'h02; step();
      tests_run++;
      if (PC !== 10'h001) begin fails++; $display("FAIL rel_wrap: PC=%h, required 001", PC); end
      branch_abs = 1; branch_idx = 5'd1; step();
      branch_en = 0; step();
      tests_run++;
      if (PC !== 10'h000) begin fails++; $display("FAIL seq_wrap: PC=%h, required 000", PC); end
      branch_en = 1; branch_abs = 0; branch_off = 8'h81; step();
      tests_run++;
      if (PC !== 10'h381) begin fails++; $display("FAIL rel_neg127: PC=%h, required 381", PC); end
   endtask

   task automatic test_stall_halt();
      relaunch();
      for (int i = 0; i < 6; i++) step();
      tests_run++;
      if (PC !== 10'd6 || cycle_count !== 16'd6 || instr_count !== 16'd6) begin
         fails++;
         $display("FAIL stall_pre: PC=%h cyc=%0d ins=%0d, required 006 6 6", PC, cycle_count, instr_count);
      end
      stall = 1; halt_req = 1; branch_en = 1; #1;
      tests_run++;
      if (fetch_valid !== 1'b0) begin fails++; $display("FAIL stall_fv: fv=%b, required 0", fetch_valid); end
      step(); step();
      tests_run++;
      if (PC !== 10'd6 || halt !== 1'b0 || cycle_count !== 16'd8 || instr_count !== 16'd6) begin
         fails++;
         $display("FAIL stall_hold: PC=%h halt=%b cyc=%0d ins=%0d, required 006 0 8 6",
                  PC, halt, cycle_count, instr_count);
      end
      stall = 0; #1;
      tests_run++;
      if (fetch_valid !== 1'b1) begin fails++; $display("FAIL unstall_fv: fv=%b, required 1", fetch_valid); end
      step();
      tests_run++;
      if (halt !== 1'b1 || PC !== 10'd6 || instr_count !== 16'd7 || cycle_count !== 16'd9 ||
          fetch_valid !== 1'b0) begin
         fails++;
         $display("FAIL halt: halt=%b PC=%h ins=%0d cyc=%0d fv=%b, required 1 006 7 9 0",
                  halt, PC, instr_count, cycle_count, fetch_valid);
      end
      halt_req = 0; branch_en = 0; step(); step();
      tests_run++;
      if (halt !== 1'b1 || PC !== 10'd6 || instr_count !== 16'd7 || cycle_count !== 16'd9) begin
         fails++;
         $display("FAIL halted_frozen: halt=%b PC=%h ins=%0d cyc=%0d, required 1 006 7 9",
                  halt, PC, instr_count, cycle_count);
      end
   endtask

   task automatic test_restart_async();
      start = 1; step();
      tests_run++;
      if (halt !== 1'b0 || PC !== 10'd0 || cycle_count !== 16'd0 || instr_count !== 16'd0) begin
         fails++;
         $display("FAIL restart: halt=%b PC=%h cyc=%0d ins=%0d, required 0 000 0 0",
                  halt, PC, cycle_count, instr_count);
      end
      start = 0; step(); step(); step();
      tests_run++;
      if (PC !== 10'd2 || fetch_valid !== 1'b1) begin
         fails++; $display("FAIL relaunch: PC=%h fv=%b, required 002 1", PC, fetch_valid);
      end
      #2; reset_n = 0; #1;
      tests_run++;
      if (PC !== 10'd0 || halt !== 1'b0 || fetch_valid !== 1'b0 ||
          cycle_count !== 16'd0 || instr_count !== 16'd0) begin
         fails++;
         $display("FAIL async_reset: PC=%h halt=%b fv=%b cyc=%0d ins=%0d, required all 0",
                  PC, halt, fetch_valid, cycle_count, instr_count);
      end
      reset_n = 1; step();
      branch_en = 1; branch_abs = 1; branch_idx = 5'd5; step();
      tests_run++;
      if (PC !== 10'd0) begin fails++; $display("FAIL lut_cleared: PC=%h, required 000", PC); end
      branch_en = 0;
   endtask

   task automatic test_saturation();
      relaunch();
      for (int i = 0; i < 65538; i++) step();
      tests_run++;
      if (cycle_count !== 16'hFFFF || instr_count !== 16'hFFFF) begin
         fails++;
         $display("FAIL saturate: cyc=%h ins=%h, required ffff ffff", cycle_count, instr_count);
      end
   endtask

`ifdef BRANCH_STATS_EN
   task automatic test_branch_stats();
      relaunch();
      branch_en = 1; branch_abs = 0; branch_off = 8'h01; step();
      stall = 1; step();
      stall = 0; step();
      halt_req = 1; stall = 1; step();
      halt_req = 0; stall = 0; branch_en = 0; step();
      tests_run++;
      if (taken_branch_count !== 16'd2) begin
         fails++; $display("FAIL branch_stats: count=%0d, required 2", taken_branch_count);
      end
      start = 1; step();
      tests_run++;
      if (taken_branch_count !== 16'd0) begin
         fails++; $display("FAIL branch_stats_clr: count=%0d, required 0", taken_branch_count);
      end
      start = 0;
   endtask
`endif

   initial begin
      reset_n = 1; start = 1;
      clear_ctl();
      test_reset();
      test_sequential();
      test_abs_branch();
      test_rel_branch();
      test_stall_halt();
      test_restart_async();
`ifdef BRANCH_STATS_EN
      test_branch_stats();
`endif
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
